// File: rtl/alu_pkg.sv
// alu_pkg -- shared definitions for the sequential 32-bit ALU.
//   * datapath widths
//   * funct code constants (req_ctl[5:0])
//   * FSM state encoding
//   * is_shift_fn(): true for the two shift functs
package alu_pkg;

  localparam int DATA_W  = 32;
  localparam int SHAMT_W = 5;
  localparam int CTL_W   = SHAMT_W + 6;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic is_shift_fn(input logic [5:0] funct);
    return (funct == FN_SLL) || (funct == FN_SRL);
  endfunction

endpackage

// File: rtl/alu_seq_shifter.sv
// alu_seq_shifter -- combinational logical shift step for alu_seq_32.
// Optional feature macro: ALU_SEQ_FAST_SHIFT_EN
//   undefined: shifts by min(SHIFT_STEP, remaining) per call (iterative mode)
//   defined  : shifts by the whole remaining amount (single-cycle barrel)
// Ports:
//   data_in       in  32  value to shift
//   shift_right   in  1   1 = logical right, 0 = logical left
//   remaining     in  5   bit positions still to shift
//   data_out      out 32  shifted value
//   remaining_out out 5   positions left after this step
// SHIFT_STEP: bits per iterative step, legal values 1, 2, 4.
module alu_seq_shifter
  import alu_pkg::*;
#(
  parameter int SHIFT_STEP = 1
) (
  input  logic [DATA_W-1:0]  data_in,
  input  logic               shift_right,
  input  logic [SHAMT_W-1:0] remaining,
  output logic [DATA_W-1:0]  data_out,
  output logic [SHAMT_W-1:0] remaining_out
);

`ifdef ALU_SEQ_FAST_SHIFT_EN
  localparam bit FAST_SHIFT = 1'b1;
`else
  localparam bit FAST_SHIFT = 1'b0;
`endif

  localparam logic [SHAMT_W-1:0] STEP = SHAMT_W'(SHIFT_STEP);

  logic [SHAMT_W-1:0] amt;

  // The last iterative step may be shorter than SHIFT_STEP.
  assign amt           = (FAST_SHIFT || (remaining < STEP)) ? remaining : STEP;
  assign remaining_out = remaining - amt;

  // Log-depth barrel: stage gi shifts by 2**gi when amt[gi] is set.
  logic [SHAMT_W:0][DATA_W-1:0] stage;
  assign stage[0] = data_in;

  generate
    for (genvar gi = 0; gi < SHAMT_W; gi++) begin : g_stage
      assign stage[gi+1] = !amt[gi]    ? stage[gi] :
                           shift_right ? (stage[gi] >> (2 ** gi)) :
                                         (stage[gi] << (2 ** gi));
    end
  endgenerate

  assign data_out = stage[SHAMT_W];

endmodule

// File: rtl/alu_seq_32.sv
// alu_seq_32 -- sequential 32-bit ALU with valid/ready request and response.
// Optional feature macro: ALU_SEQ_FAST_SHIFT_EN (single-cycle SLL/SRL;
// without it shifts iterate SHIFT_STEP bits per cycle in the SHIFT state).
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   req_valid/req_ready              request handshake (ready only in IDLE)
//   req_a, req_b [31:0]              operands
//   req_ctl [10:0]                   [10:6] shamt, [5:0] funct
//   rsp_valid/rsp_ready              response handshake (valid only in DONE)
//   rsp_z [31:0]                     result
//   rsp_overflow, rsp_carryout,
//   rsp_zero, rsp_illegal            flags
module alu_seq_32
  import alu_pkg::*;
#(
  parameter int SHIFT_STEP = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic [CTL_W-1:0]  req_ctl,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_z,
  output logic              rsp_overflow,
  output logic              rsp_carryout,
  output logic              rsp_zero,
  output logic              rsp_illegal
);

`ifdef ALU_SEQ_FAST_SHIFT_EN
  localparam bit FAST_SHIFT = 1'b1;
`else
  localparam bit FAST_SHIFT = 1'b0;
`endif

  state_t state_reg, state_next;

  logic [DATA_W-1:0]  a_reg, b_reg;
  logic [CTL_W-1:0]   ctl_reg;
  logic [DATA_W-1:0]  z_reg, z_next;
  logic               ovf_reg, ovf_next;
  logic               cout_reg, cout_next;
  logic               zero_reg, zero_next;
  logic               ill_reg, ill_next;
  logic [SHAMT_W-1:0] rem_reg, rem_next;

  logic               accept;
  logic [5:0]         funct;
  logic [SHAMT_W-1:0] shamt;
  logic               shift_iter;
  logic [DATA_W:0]    add_sum, sub_sum;
  logic               slt, sltu;

  logic [DATA_W-1:0]  sh_in, sh_out;
  logic [SHAMT_W-1:0] sh_rem_in, sh_rem_out;

  assign accept = req_valid && req_ready;
  assign funct  = ctl_reg[5:0];
  assign shamt  = ctl_reg[CTL_W-1:6];

  // Only the iterative build with a non-zero amount needs the SHIFT state.
  assign shift_iter = is_shift_fn(funct) && !FAST_SHIFT && (shamt != '0);

  assign add_sum = {1'b0, a_reg} + {1'b0, b_reg};
  assign sub_sum = {1'b0, a_reg} + {1'b0, ~b_reg} + {{DATA_W{1'b0}}, 1'b1};
  assign slt     = $signed(a_reg) < $signed(b_reg);
  assign sltu    = a_reg < b_reg;

  // In EXEC the shifter sees the operand (fast build shifts it completely);
  // in SHIFT it iterates on the working value held in z_reg.
  assign sh_in     = (state_reg == ST_SHIFT) ? z_reg   : a_reg;
  assign sh_rem_in = (state_reg == ST_SHIFT) ? rem_reg : shamt;

  alu_seq_shifter #(
    .SHIFT_STEP (SHIFT_STEP)
  ) u_shifter (
    .data_in       (sh_in),
    .shift_right   (funct == FN_SRL),
    .remaining     (sh_rem_in),
    .data_out      (sh_out),
    .remaining_out (sh_rem_out)
  );

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (accept) state_next = ST_EXEC;
      ST_EXEC:  state_next = shift_iter ? ST_SHIFT : ST_DONE;
      ST_SHIFT: if (sh_rem_out == '0) state_next = ST_DONE;
      ST_DONE:  if (rsp_ready) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    req_ready = (state_reg == ST_IDLE);
    rsp_valid = (state_reg == ST_DONE);
  end

  // ---------------- datapath next values ----------------
  always_comb begin
    z_next    = z_reg;
    ovf_next  = ovf_reg;
    cout_next = cout_reg;
    zero_next = zero_reg;
    ill_next  = ill_reg;
    rem_next  = rem_reg;
    case (state_reg)
      ST_EXEC: begin
        ovf_next  = 1'b0;
        cout_next = 1'b0;
        ill_next  = 1'b0;
        rem_next  = '0;
        case (funct)
          FN_ADD: begin
            z_next    = add_sum[DATA_W-1:0];
            cout_next = add_sum[DATA_W];
            ovf_next  = (a_reg[DATA_W-1] == b_reg[DATA_W-1]) &&
                        (add_sum[DATA_W-1] != a_reg[DATA_W-1]);
          end
          FN_SUB: begin
            z_next    = sub_sum[DATA_W-1:0];
            cout_next = sub_sum[DATA_W];
            ovf_next  = (a_reg[DATA_W-1] != b_reg[DATA_W-1]) &&
                        (sub_sum[DATA_W-1] != a_reg[DATA_W-1]);
          end
          FN_AND:  z_next = a_reg & b_reg;
          FN_OR:   z_next = a_reg | b_reg;
          FN_XOR:  z_next = a_reg ^ b_reg;
          FN_NOR:  z_next = ~(a_reg | b_reg);
          FN_SLT:  z_next = {{(DATA_W-1){1'b0}}, slt};
          FN_SLTU: z_next = {{(DATA_W-1){1'b0}}, sltu};
          FN_SLL, FN_SRL: begin
            if (shift_iter) begin
              z_next   = a_reg;
              rem_next = shamt;
            end else begin
              // Fast build: full barrel result; iterative with shamt 0: A.
              z_next = sh_out;
            end
          end
          default: begin
            z_next   = '0;
            ill_next = 1'b1;
          end
        endcase
        zero_next = (z_next == '0);
      end
      ST_SHIFT: begin
        z_next    = sh_out;
        rem_next  = sh_rem_out;
        zero_next = (sh_out == '0);
      end
      default: ;
    endcase
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg    <= '0;
      b_reg    <= '0;
      ctl_reg  <= '0;
      z_reg    <= '0;
      ovf_reg  <= 1'b0;
      cout_reg <= 1'b0;
      zero_reg <= 1'b0;
      ill_reg  <= 1'b0;
      rem_reg  <= '0;
    end else begin
      if (accept) begin
        a_reg   <= req_a;
        b_reg   <= req_b;
        ctl_reg <= req_ctl;
      end
      z_reg    <= z_next;
      ovf_reg  <= ovf_next;
      cout_reg <= cout_next;
      zero_reg <= zero_next;
      ill_reg  <= ill_next;
      rem_reg  <= rem_next;
    end
  end

  assign rsp_z        = z_reg;
  assign rsp_overflow = ovf_reg;
  assign rsp_carryout = cout_reg;
  assign rsp_zero     = zero_reg;
  assign rsp_illegal  = ill_reg;

endmodule

// File: tb/tb_alu_seq_32.sv
// tb_alu_seq_32 -- scoreboard bench for alu_seq_32 (SHIFT_STEP = 4).
// Honors ALU_SEQ_FAST_SHIFT_EN when computing expected latency.
module tb_alu_seq_32;

  localparam int TB_STEP = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic [10:0] req_ctl = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_z;
  logic        rsp_overflow, rsp_carryout, rsp_zero, rsp_illegal;

  int errors = 0;
  int checks = 0;
  int txn    = 0;

  typedef struct {
    logic [10:0] ctl;
    logic [31:0] a, b, z;
    logic        ovf, cout, zero, ill;
    int          lat;
  } exp_t;

  exp_t sb_q[$];

  alu_seq_32 #(.SHIFT_STEP(TB_STEP)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_ctl      (req_ctl),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_z        (rsp_z),
    .rsp_overflow (rsp_overflow),
    .rsp_carryout (rsp_carryout),
    .rsp_zero     (rsp_zero),
    .rsp_illegal  (rsp_illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: plain integer arithmetic.
  function automatic exp_t model(input logic [5:0] f, input logic [4:0] sh,
                                 input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint sa, sb, s;
    logic [63:0] wide;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.ctl = {sh, f}; e.a = a; e.b = b;
    e.z = '0; e.ovf = 1'b0; e.cout = 1'b0; e.ill = 1'b0; e.lat = 1;
    case (f)
      6'b100000: begin
        wide   = {32'd0, a} + {32'd0, b};
        e.z    = wide[31:0];
        e.cout = wide[32];
        s      = sa + sb;
        e.ovf  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      6'b100010: begin
        e.z    = a - b;
        e.cout = (a >= b);
        s      = sa - sb;
        e.ovf  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      6'b100100: e.z = a & b;
      6'b100101: e.z = a | b;
      6'b100110: e.z = a ^ b;
      6'b100111: e.z = ~(a | b);
      6'b101010: e.z = (sa < sb) ? 32'd1 : 32'd0;
      6'b101011: e.z = (a < b) ? 32'd1 : 32'd0;
      6'b000000, 6'b000010: begin
        e.z = (f == 6'b000000) ? (a << sh) : (a >> sh);
`ifndef ALU_SEQ_FAST_SHIFT_EN
        if (sh != 0) e.lat = 1 + (int'(sh) + TB_STEP - 1) / TB_STEP;
`endif
      end
      default: e.ill = 1'b1;
    endcase
    e.zero = (e.z == 32'd0);
    return e;
  endfunction

  task automatic do_req(input logic [5:0] f, input logic [4:0] sh,
                        input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    check("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_a     = a;
    req_b     = b;
    req_ctl   = {sh, f};
    sb_q.push_back(model(f, sh, a, b));
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    // Scramble the inputs: the latched operands must be what gets used.
    req_a   = $urandom;
    req_b   = $urandom;
    req_ctl = 11'($urandom);
  endtask

  task automatic get_rsp(input int hold);
    exp_t        e;
    int          cnt;
    logic [31:0] z_seen;
    cnt = 0;
    rsp_ready = (hold == 0);
    e = sb_q.pop_front();
    do begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
    end while (!rsp_valid && cnt < 200);
    txn++;
    if (!rsp_valid) begin
      check("rsp_timeout", 32'd0, 32'd1);
      return;
    end
    $display("txn %0d: ctl=%h a=%h b=%h -> z=%h ovf=%b cout=%b zero=%b ill=%b lat=%0d",
             txn, e.ctl, e.a, e.b, rsp_z, rsp_overflow, rsp_carryout, rsp_zero, rsp_illegal, cnt);
    check("latency",  cnt,                  e.lat);
    check("rsp_z",    rsp_z,                e.z);
    check("overflow", {31'd0, rsp_overflow}, {31'd0, e.ovf});
    check("carryout", {31'd0, rsp_carryout}, {31'd0, e.cout});
    check("zero",     {31'd0, rsp_zero},     {31'd0, e.zero});
    check("illegal",  {31'd0, rsp_illegal},  {31'd0, e.ill});
    z_seen = rsp_z;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("hold_valid", {31'd0, rsp_valid}, 32'd1);
      check("hold_z",     rsp_z,              z_seen);
      check("hold_ready", {31'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post_hs_valid", {31'd0, rsp_valid}, 32'd0);
    check("post_hs_ready", {31'd0, req_ready}, 32'd1);
  endtask

  task automatic run(input logic [5:0] f, input logic [4:0] sh,
                     input logic [31:0] a, input logic [31:0] b, input int hold);
    do_req(f, sh, a, b);
    get_rsp(hold);
  endtask

  logic [5:0] fn_list [11] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110,
                               6'b100111, 6'b101010, 6'b101011, 6'b000000, 6'b000010,
                               6'b010101};

  initial begin
    int seen;
    // Reset state
    #1;
    check("rst_valid",   {31'd0, rsp_valid}, 32'd0);
    check("rst_ready",   {31'd0, req_ready}, 32'd1);
    check("rst_z",       rsp_z,              32'd0);
    check("rst_flags",   {28'd0, rsp_overflow, rsp_carryout, rsp_zero, rsp_illegal}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    run(6'b100000, 5'd0,  32'h7FFFFFFF, 32'h00000001, 0);  // ADD overflow
    run(6'b100010, 5'd0,  32'h00000005, 32'h00000005, 0);  // SUB to zero
    run(6'b101010, 5'd0,  32'hFFFFFFFF, 32'h00000001, 0);  // SLT
    run(6'b101011, 5'd0,  32'hFFFFFFFF, 32'h00000001, 0);  // SLTU
    run(6'b100100, 5'd0,  32'hF0F0F0F0, 32'hFF00FF00, 5);  // AND, held response
    run(6'b000000, 5'd31, 32'h00000001, 32'h0,        0);  // SLL 31
    run(6'b000010, 5'd0,  32'h80000000, 32'h0,        0);  // SRL 0
    run(6'b000010, 5'd4,  32'h80000000, 32'h0,        0);  // SRL 4
    run(6'b111111, 5'd0,  32'h12345678, 32'h9ABCDEF0, 0);  // illegal
    run(6'b100000, 5'd0,  32'hFFFFFFFF, 32'h00000001, 0);  // ADD carry, zero
    run(6'b100010, 5'd0,  32'h00000001, 32'h00000002, 0);  // SUB borrow
    run(6'b100010, 5'd0,  32'h80000000, 32'h00000001, 0);  // SUB overflow
    run(6'b000000, 5'd5,  32'hF0000001, 32'h0,        1);  // SLL partial step

    // Random mix
    for (int i = 0; i < 16; i++) begin
      run(fn_list[$urandom_range(0, 10)], 5'($urandom), $urandom, $urandom, $urandom_range(0, 2));
    end

    // Reset in the middle of a long shift: operation must vanish.
    do_req(6'b000000, 5'd20, 32'h00012345, 32'h0);
    @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", {31'd0, rsp_valid}, 32'd0);
    check("midrst_z",     rsp_z,              32'd0);
    check("midrst_flags", {28'd0, rsp_overflow, rsp_carryout, rsp_zero, rsp_illegal}, 32'd0);
    void'(sb_q.pop_front());
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("no_rsp_after_rst", seen,                0);
    check("ready_after_rst",  {31'd0, req_ready}, 32'd1);

    // Normal operation resumes after reset.
    run(6'b100110, 5'd0, 32'hA5A5A5A5, 32'h5A5A5A5A, 0);
    run(6'b100111, 5'd0, 32'h00000000, 32'h00000000, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_seq_32.md
ALU_SEQ_32 -- requirements
Module: alu_seq_32

Interface
REQ-001 SHALL have parameter SHIFT_STEP, default 1, bits shifted per SHIFT cycle; legal values 1, 2, 4.
REQ-002 SHALL have port clk  input  1  single clock for all state, rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port req_valid  input  1  request offered.
REQ-005 SHALL have port req_ready  output  1  request accepted when high with req_valid.
REQ-006 SHALL have port req_a  input  32  operand A.
REQ-007 SHALL have port req_b  input  32  operand B.
REQ-008 SHALL have port req_ctl  input  11  [10:6] shamt, [5:0] funct code.
REQ-009 SHALL have port rsp_valid  output  1  response held.
REQ-010 SHALL have port rsp_ready  input  1  consumer takes response.
REQ-011 SHALL have port rsp_z  output  32  result.
REQ-012 SHALL have ports rsp_overflow, rsp_carryout, rsp_zero, rsp_illegal  output  1 each  flags.

Function
REQ-013 SHALL implement FSM IDLE, EXEC, SHIFT, DONE; req_ready = (state==IDLE); rsp_valid = (state==DONE).
REQ-014 SHALL on req_valid&&req_ready latch req_a, req_b, req_ctl and go to EXEC; inputs are ignored outside IDLE.
REQ-015 SHALL support funct: ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, NOR 100111, SLT 101010, SLTU 101011, SLL 000000, SRL 000010.
REQ-016 SHALL in EXEC, for non-shift funct, register result and flags and go to DONE next edge (response one cycle after acceptance edge).
REQ-017 SHALL compute ADD/SUB modulo 2^32; rsp_overflow = signed overflow; rsp_carryout = bit 32 of A+B (ADD) or A+~B+1 (SUB, 1 = no borrow).
REQ-018 SHALL drive rsp_overflow=0 and rsp_carryout=0 for every funct other than ADD/SUB.
REQ-019 SHALL produce SLT/SLTU as 32'h1 when A<B (signed/unsigned), else 0.
REQ-020 SHALL for SLL/SRL with shamt=0 go EXEC->DONE with rsp_z=A; with shamt>0 go EXEC->SHIFT.
REQ-021 SHALL in SHIFT shift the working register logically by min(SHIFT_STEP, remaining) per cycle, decrement remaining, go to DONE on the edge remaining reaches 0; SHIFT occupies ceil(shamt/SHIFT_STEP) cycles.
REQ-022 SHALL treat unlisted funct as illegal: rsp_z=0, rsp_illegal=1, other flags 0, latency as REQ-016.
REQ-023 SHALL set rsp_zero = (rsp_z==0) for every funct, including illegal.
REQ-024 SHALL in DONE hold all rsp_* stable until rsp_ready; on rsp_valid&&rsp_ready go to IDLE (no request accepted that same edge).

Reset
REQ-025 SHALL on rst_n low, immediately and asynchronously, enter IDLE, clear rsp_z and all flags to 0, req_ready=1 after release, rsp_valid=0.
REQ-026 SHALL on reset during EXEC, SHIFT or DONE discard the operation without any response.

Configuration
REQ-027 SHALL with ALU_SEQ_FAST_SHIFT_EN defined compute SLL/SRL in EXEC with a single-cycle barrel shift (latency per REQ-016, SHIFT state never entered, SHIFT_STEP ignored).
REQ-028 SHALL without ALU_SEQ_FAST_SHIFT_EN use the iterative shift of REQ-020/REQ-021.

Structure
REQ-029 SHALL place funct code constants and the FSM state encoding in shared package alu_pkg.
REQ-030 SHALL implement the shift datapath (iterative and fast variants) in sub-module alu_seq_shifter; all other logic in alu_seq_32.

Verification
REQ-031 ADD A=7FFFFFFF B=00000001, rsp_ready=1 -> rsp_valid one cycle after acceptance, rsp_z=80000000, overflow=1, carryout=0, zero=0.
REQ-032 SUB A=00000005 B=00000005 -> rsp_z=0, zero=1, carryout=1, overflow=0; SLT A=FFFFFFFF B=1 -> 1; SLTU same operands -> 0.
REQ-033 SLL A=00000001 shamt=31, SHIFT_STEP=1, no FAST macro -> 31 SHIFT cycles, rsp_z=80000000; SHIFT_STEP=4 -> 8 SHIFT cycles, same result.
REQ-034 SRL A=80000000 shamt=0 -> rsp_z=80000000, no SHIFT cycles; with ALU_SEQ_FAST_SHIFT_EN, SRL shamt=4 -> rsp_z=08000000 one cycle after acceptance.
REQ-035 Hold rsp_ready=0 for 5 cycles after AND A=F0F0F0F0 B=FF00FF00 -> rsp_z=F000F000 stable, req_ready=0 throughout, IDLE after handshake.
REQ-036 Assert rst_n=0 mid-SHIFT (SLL shamt=20) -> rsp_valid=0 immediately, all outputs 0, no response after release; funct 111111 -> rsp_illegal=1, rsp_z=0, zero=1.
